// File: rtl/key_entry_sequencer.sv
// -----------------------------------------------------------------------------
// key_entry_sequencer
//
// Sits between the board push-buttons and the lock FSM. Turns raw key levels
// into one-shot digit events, assembles PASSWORD_LENGTH digits into one word
// (first digit in the most-significant nibble), and offers that word to the
// FSM over a valid/ready handshake.
//
// Optional feature macro: KEY_SEQ_IDLE_TIMEOUT_EN
//   defined   -> an idle watchdog aborts a capture after MAX_IDLE quiet cycles
//                and pulses idle_timeout for one cycle.
//   undefined -> no watchdog; idle_timeout is tied low and a capture ends only
//                on completion or when enable drops.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   key          in   [3:0] button levels (already synchronised); value = digit
//   enable       in   level request from the FSM to capture a password
//   pwd_ready    in   FSM can accept the assembled password
//   pwd_valid    out  pwd_data holds a complete password
//   pwd_data     out  [4*PASSWORD_LENGTH-1:0] assembled digits
//   digit_count  out  digits captured so far
//   busy         out  high while capturing or presenting
//   idle_timeout out  one-cycle pulse when the watchdog aborts a capture
// -----------------------------------------------------------------------------
module key_entry_sequencer #(
    parameter int PASSWORD_LENGTH = 4,
    parameter int MAX_IDLE        = 50
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [3:0]                           key,
    input  logic                                 enable,
    input  logic                                 pwd_ready,
    output logic                                 pwd_valid,
    output logic [4*PASSWORD_LENGTH-1:0]         pwd_data,
    output logic [$clog2(PASSWORD_LENGTH+1)-1:0] digit_count,
    output logic                                 busy,
    output logic                                 idle_timeout
);

    localparam int DW = 4 * PASSWORD_LENGTH;
    localparam int CW = $clog2(PASSWORD_LENGTH + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    if (PASSWORD_LENGTH < 1 || MAX_IDLE < 1) begin : g_bad_param
        $error("key_entry_sequencer: PASSWORD_LENGTH and MAX_IDLE must be >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [3:0]    key_prev_q;
    logic [DW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;

`ifdef KEY_SEQ_IDLE_TIMEOUT_EN
    localparam int IW = (MAX_IDLE > 1) ? $clog2(MAX_IDLE) : 1;
    logic [IW-1:0] idle_q, idle_d;
    logic          tmo_q, tmo_d;
    logic          expire;

    assign expire = (idle_q == IW'(MAX_IDLE - 1));
`endif

    // Rising edge from all-released to any key; held keys and changes between
    // two non-zero values do not retrigger.
    assign press = (key != 4'd0) && (key_prev_q == 4'd0);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
`ifdef KEY_SEQ_IDLE_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                buf_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Dropping enable is a silent abort and outranks everything.
                if (!enable) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (press) begin
                    buf_d = (buf_q << 4) | DW'(key);
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(PASSWORD_LENGTH - 1)) begin
                        state_d = S_PRESENT;
                    end
                end
`ifdef KEY_SEQ_IDLE_TIMEOUT_EN
                // A press on the expiry cycle is handled above and wins.
                else if (expire) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end
`endif
            end
            S_PRESENT: begin
                if (pwd_ready) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_SEQ_IDLE_TIMEOUT_EN
    // Counts quiet cycles while capturing; zero outside CAPTURE so entry
    // always starts from a cleared counter.
    always_comb begin
        idle_d = '0;
        if (state_q == S_CAPTURE && !press) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    assign idle_timeout = tmo_q;
`else
    assign idle_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            key_prev_q <= 4'd0;
            buf_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pwd_valid   = (state_q == S_PRESENT);
    assign busy        = (state_q == S_CAPTURE) || (state_q == S_PRESENT);
    assign pwd_data    = buf_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Scoreboard bench for key_entry_sequencer. A reference model advances once
// per clock edge from the applied inputs; completed passwords and watchdog
// aborts are queued as expected events and a separate monitor pops them when
// the DUT presents a transfer or an idle_timeout pulse.
module tb_key_entry_sequencer;

    localparam int L  = 4;
    localparam int MI = 50;
`ifdef KEY_SEQ_IDLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key = 4'd0;
    logic        enable = 1'b0;
    logic        pwd_ready = 1'b0;
    logic        pwd_valid;
    logic [15:0] pwd_data;
    logic [2:0]  digit_count;
    logic        busy;
    logic        idle_timeout;

    key_entry_sequencer #(.PASSWORD_LENGTH(L), .MAX_IDLE(MI)) dut (
        .clock(clock), .reset(reset), .key(key), .enable(enable),
        .pwd_ready(pwd_ready), .pwd_valid(pwd_valid), .pwd_data(pwd_data),
        .digit_count(digit_count), .busy(busy), .idle_timeout(idle_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_tmo;
        logic [15:0] data;
        int          cyc;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Reference model state
    bit    m_cap = 0;
    bit    m_pres = 0;
    bit    m_tmo = 0;
    int    m_prev = 0;
    int    m_quiet = 0;
    int    m_digits[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_value();
        logic [15:0] v = 16'd0;
        foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_cap = 0; m_pres = 0; m_tmo = 0; m_prev = 0; m_quiet = 0;
        m_digits.delete();
    endtask

    task automatic model_step();
        bit    pr;
        item_t it;
        m_tmo = 0;
        if (!reset) begin
            model_reset();
            return;
        end
        pr = (key != 4'd0) && (m_prev == 0);
        m_prev = int'(key);
        if (m_pres) begin
            if (pwd_ready) begin
                m_pres = 0;
                m_digits.delete();
            end
        end else if (m_cap) begin
            if (!enable) begin
                m_cap = 0;
                m_digits.delete();
            end else if (pr) begin
                m_digits.push_back(int'(key));
                m_quiet = 0;
                if (m_digits.size() == L) begin
                    m_cap = 0; m_pres = 1;
                    it.is_tmo = 0; it.data = model_value(); it.cyc = cyc;
                    sb.push_back(it);
                end
            end else begin
                m_quiet++;
                if (TMO_EN && m_quiet == MI) begin
                    m_cap = 0; m_tmo = 1;
                    m_digits.delete();
                    it.is_tmo = 1; it.data = 16'd0; it.cyc = cyc;
                    sb.push_back(it);
                end
            end
        end else if (enable) begin
            m_cap = 1;
            m_quiet = 0;
        end
    endtask

    // Advance one edge: the model consumes the inputs that edge samples, then
    // the next inputs are applied a little after the edge.
    task automatic tick(input logic [3:0] k, input logic e, input logic r);
        @(posedge clock);
        cyc++;
        model_step();
        #2;
        key = k; enable = e; pwd_ready = r;
    endtask

    task automatic press_digit(input logic [3:0] d);
        tick(d, 1'b1, 1'b0);
        tick(d, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
    endtask

    // Monitor: compares mid-cycle and pops expected events as the DUT shows them.
    always @(negedge clock) begin
        item_t it;
        chk("busy", busy, m_cap || m_pres);
        chk("pwd_valid", pwd_valid, m_pres);
        chk("digit_count", digit_count, m_digits.size());
        chk("pwd_data", pwd_data, model_value());
        chk("idle_timeout", idle_timeout, m_tmo);
        if (idle_timeout) begin
            chk("sb_has_timeout", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk("timeout_kind", it.is_tmo, 1);
                chk("timeout_cycle", it.cyc, cyc);
            end
        end
        if (reset && pwd_valid && pwd_ready) begin
            chk("sb_has_xfer", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk("xfer_kind", it.is_tmo, 0);
                chk("xfer_data", pwd_data, it.data);
            end
        end
    end

    initial begin
        logic [3:0] d;
        logic       en, rdy;
        int         hold, gap;

        #1 reset = 1'b0;
        model_reset();
        repeat (3) tick(4'd0, 1'b0, 1'b0);
        chk("reset_busy", busy, 0);
        chk("reset_data", pwd_data, 0);
        reset = 1'b1;

        // Basic entry of 1,2,3,4 then a one-cycle transfer
        tick(4'd0, 1'b1, 1'b0);
        press_digit(4'h1); press_digit(4'h2); press_digit(4'h3); press_digit(4'h4);
        chk("tp1_data", pwd_data, 16'h1234);
        chk("tp1_count", digit_count, 4);
        chk("tp1_valid", pwd_valid, 1);
        tick(4'd0, 1'b1, 1'b1);
        tick(4'd0, 1'b0, 1'b0);
        chk("tp1_valid_after", pwd_valid, 0);
        chk("tp1_count_after", digit_count, 0);
        chk("tp1_busy_after", busy, 0);

        // Held key and non-zero change give a single event
        repeat (2) tick(4'd0, 1'b1, 1'b0);
        repeat (10) tick(4'hF, 1'b1, 1'b0);
        repeat (3) tick(4'h7, 1'b1, 1'b0);
        tick(4'd0, 1'b1, 1'b0);
        chk("held_count", digit_count, 1);
        chk("held_nibble", pwd_data[3:0], 4'hF);
        repeat (2) tick(4'd0, 1'b0, 1'b0);

        // Single press then silence
        repeat (2) tick(4'd0, 1'b1, 1'b0);
        tick(4'h7, 1'b1, 1'b0);
        repeat (55) tick(4'd0, 1'b1, 1'b0);
        repeat (2) tick(4'd0, 1'b0, 1'b0);

        // Press on the expiry cycle wins, then a later full timeout
        repeat (2) tick(4'd0, 1'b1, 1'b0);
        tick(4'h7, 1'b1, 1'b0);
        repeat (49) tick(4'd0, 1'b1, 1'b0);
        tick(4'h3, 1'b1, 1'b0);
        repeat (60) tick(4'd0, 1'b1, 1'b0);
        repeat (2) tick(4'd0, 1'b0, 1'b0);

        // enable low on the expiry cycle: silent abort
        repeat (2) tick(4'd0, 1'b1, 1'b0);
        tick(4'h9, 1'b1, 1'b0);
        repeat (49) tick(4'd0, 1'b1, 1'b0);
        repeat (3) tick(4'd0, 1'b0, 1'b0);

        // Two digits, then enable drops
        tick(4'd0, 1'b1, 1'b0);
        press_digit(4'h2); press_digit(4'h5);
        repeat (3) tick(4'd0, 1'b0, 1'b0);
        chk("abort_data", pwd_data, 0);

        // Asynchronous reset while presenting FFFF
        tick(4'd0, 1'b1, 1'b0);
        repeat (4) press_digit(4'hF);
        chk("pre_reset_data", pwd_data, 16'hFFFF);
        reset = 1'b0;
        model_reset();
        sb.delete();
        #1;
        chk("async_valid", pwd_valid, 0);
        chk("async_data", pwd_data, 0);
        chk("async_count", digit_count, 0);
        chk("async_busy", busy, 0);
        chk("async_tmo", idle_timeout, 0);
        repeat (2) tick(4'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Randomised traffic
        repeat (400) begin
            en   = ($urandom_range(0, 99) < 94);
            d    = 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) gap = $urandom_range(40, 60);
            rdy  = 1'($urandom_range(0, 1));
            repeat (hold) tick(d, en, rdy);
            if ($urandom_range(0, 6) == 0) tick(4'((int'(d) % 15) + 1), en, rdy);
            repeat (gap) tick(4'd0, en, 1'($urandom_range(0, 1)));
        end

        // Drain any pending password, then confirm nothing was left unseen
        repeat (5) tick(4'd0, 1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_entry_sequencer.md
# key_entry_sequencer

Controller sitting between the board push-buttons and `DigitalLockFSM`. Turns raw `key` levels into one-shot digit events, assembles `PASSWORD_LENGTH` digits into a password word, and presents it to the lock FSM over a valid/ready handshake. An idle watchdog aborts a partial entry that stalls for too long, so the FSM never waits on a half-typed code.

## Interface
Parameters:
- `PASSWORD_LENGTH`, 4: number of digits per password; must be ≥1.
- `MAX_IDLE`, 50: clock cycles without a digit before a capture aborts; must be ≥1.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key`  in  4  button levels, active-high, already synchronised; the 4-bit value is the digit.
- `enable`  in  1  level request from the FSM to capture a password.
- `pwd_ready`  in  1  FSM can accept the assembled password.
- `pwd_valid`  out  1  `pwd_data` holds a complete password.
- `pwd_data`  out  4*PASSWORD_LENGTH  assembled digits; the first digit is in the most-significant nibble.
- `digit_count`  out  $clog2(PASSWORD_LENGTH+1)  digits captured so far.
- `busy`  out  1  high in CAPTURE or PRESENT.
- `idle_timeout`  out  1  one-cycle pulse when a capture is aborted by the watchdog.

## Operation
- Press event: `key != 0` this cycle and `key == 0` in the previous cycle.
  - The previous-key register updates in every state, including IDLE.
  - A held key produces exactly one event.
  - A change between two non-zero values produces no event.
- State IDLE:
  - Buffer, `digit_count` and idle counter are held at 0.
  - Press events are ignored.
  - `enable == 1` moves to CAPTURE.
- State CAPTURE:
  - Each press event shifts `key` into the buffer: `pwd_data <= {pwd_data[4*PASSWORD_LENGTH-5:0], key}`.
  - Each press event increments `digit_count`.
  - When the press brings `digit_count` to `PASSWORD_LENGTH`, go to PRESENT.
  - If `enable` drops, abort to IDLE and clear buffer and count. No timeout pulse is issued.
- State PRESENT:
  - `pwd_valid = 1`; `pwd_data` is frozen.
  - Press events and `enable` are ignored.
  - Transfer happens on a rising edge with `pwd_valid && pwd_ready`. Go to IDLE and clear buffer and count.
- Idle watchdog (CAPTURE only):
  - The counter clears on entry to CAPTURE and on every press event. Otherwise it increments each cycle.
  - When the counter equals `MAX_IDLE-1` with no press that cycle: pulse `idle_timeout`, clear buffer and count, go to IDLE.
- Simultaneous events:
  - A press on the expiry cycle wins; the counter clears and there is no timeout.
  - `enable` low on the expiry cycle takes the silent-abort path; there is no pulse.
- Encoding: states are IDLE=0, CAPTURE=1, PRESENT=2. The unused encoding recovers to IDLE.

## Timing
- Reset values, asynchronous:
  - State IDLE.
  - `pwd_valid=0`, `pwd_data=0`, `digit_count=0`, `busy=0`, `idle_timeout=0`.
  - Previous-key register = 0.
- IDLE→CAPTURE: `busy` goes high after the edge that samples `enable=1`. A press in that same cycle is not captured.
- Digit latency: the buffer and `digit_count` update at the edge that samples the press event.
- `pwd_valid` rises after the edge that samples the final digit.
- `pwd_valid` falls after the transfer edge. Holding `pwd_ready` high gives a transfer on the first PRESENT cycle.
- Timeout: with no presses after entering CAPTURE at edge E, `idle_timeout` is high for the single cycle following edge E+MAX_IDLE. `busy` is low in that same cycle.
- Reset asserted mid-capture or mid-present clears everything immediately; there is no pulse on `idle_timeout`.

## Configuration
- `KEY_SEQ_IDLE_TIMEOUT_EN` defined: the watchdog is built as described above.
- `KEY_SEQ_IDLE_TIMEOUT_EN` undefined: no idle counter. `idle_timeout` is tied to 0. CAPTURE exits only by completion or by `enable` dropping.

## Test plan
- Reset, then `enable=1` and presses 1,2,3,4, each held 2 cycles with 2 released cycles between, `pwd_ready=0` → `pwd_data=16'h1234`, `digit_count=4`, `pwd_valid` high. Then `pwd_ready=1` for 1 cycle → `pwd_valid=0`, `digit_count=0`, `busy=0`.
- Hold `key=4'hF` for 10 cycles in CAPTURE, then change it to `4'h7` without releasing → `digit_count=1`, low nibble `F`.
- Enter CAPTURE, press 7 once, then idle → `idle_timeout` is a single-cycle pulse exactly 50 cycles after the press edge; `digit_count=0`, state IDLE.
- Press on cycle 49 after the last press → no timeout; `digit_count` increments; the next timeout occurs 50 cycles later.
- Two digits captured, then `enable=0` → IDLE next cycle, buffer 0, `idle_timeout` never high.
- `reset=0` while in PRESENT with `pwd_data=16'hFFFF` → all outputs 0 asynchronously, before the next clock edge.
